mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer for the shared 4:1 bit mux (Ent/Sel/Sal).

---
 rtl/mux_rr_arbiter.sv | 98 +++++++++
 tb/tb_mux_rr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 bit mux.
// Grants one requester at a time, drives Sel and registers the selected bit.
module mux_rr_arbiter #(
  parameter int HOLD = 8,
  parameter int CW   = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Req,
  input  logic [3:0] Ent,
  output logic [3:0] Gnt,
  output logic [1:0] Sel,
  output logic       Busy,
  output logic       Sal,
  output logic       Vld
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [0:0]    state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;

  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;
  logic       rel;

  assign Busy = |Gnt;

  // During a grant the search starts just past the current holder.
  always_comb begin
    rel   = (state == GRANT) && (!Req[Sel] || cnt == LAST);
    base  = (state == GRANT) ? Sel + 2'd1 : ptr;
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && Req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      Gnt   <= 4'b0000;
      Sel   <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            Gnt   <= 4'b0001 << win;
            Sel   <= win;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr <= Sel + 2'd1;
            cnt <= '0;
            if (found) begin
              Gnt <= 4'b0001 << win;
              Sel <= win;
            end else begin
              Gnt   <= 4'b0000;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Vld <= 1'b0;
      Sal <= 1'b0;
    end else begin
      Vld <= Busy;
      Sal <= Busy ? Ent[Sel] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with HOLD=4.
// Expected outputs are queued per edge and compared after the edge.
module tb_mux_rr_arbiter;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Req = 4'b0000;
  logic [3:0] Ent = 4'b0000;
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic       Busy;
  logic       Sal;
  logic       Vld;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       sal;
    logic       vld;
    string      tag;
  } exp_t;

  exp_t sb[$];

  mux_rr_arbiter #(.HOLD(4), .CW(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .Req (Req),
    .Ent (Ent),
    .Gnt (Gnt),
    .Sel (Sel),
    .Busy(Busy),
    .Sal (Sal),
    .Vld (Vld)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"}, {4'b0, Gnt}, 8'h00);
    chk({tag, ".sel"}, {6'b0, Sel}, 8'h00);
    chk({tag, ".busy"}, {7'b0, Busy}, 8'h00);
    chk({tag, ".sal"}, {7'b0, Sal}, 8'h00);
    chk({tag, ".vld"}, {7'b0, Vld}, 8'h00);
  endtask

  task automatic tick(input string tag, input logic [3:0] req,
                      input logic [3:0] ent, input logic [3:0] gnt,
                      input logic [1:0] sel, input logic sal,
                      input logic vld);
    exp_t e;
    exp_t o;
    Req = req;
    Ent = ent;
    e.gnt  = gnt;
    e.sel  = sel;
    e.busy = |gnt;
    e.sal  = sal;
    e.vld  = vld;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    o = sb.pop_front();
    chk({o.tag, ".gnt"}, {4'b0, Gnt}, {4'b0, o.gnt});
    chk({o.tag, ".sel"}, {6'b0, Sel}, {6'b0, o.sel});
    chk({o.tag, ".busy"}, {7'b0, Busy}, {7'b0, o.busy});
    chk({o.tag, ".sal"}, {7'b0, Sal}, {7'b0, o.sal});
    chk({o.tag, ".vld"}, {7'b0, Vld}, {7'b0, o.vld});
  endtask

  initial begin
    logic [3:0] ent2;
    logic [1:0] s;
    logic [1:0] ps;
    #1;
    chk_zero("reset");
    @(negedge Clk);
    Rst = 1'b0;

    // Lone requester 2: granted after one edge, regranted with no gap.
    tick("t1.grant", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      tick("t1.hold", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);

    // Wrap-around: after 2, requester 0 beats 1, then 1 follows.
    tick("t4.wrap0", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      tick("t4.hold0", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    tick("t4.next1", 4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b1);
    tick("t4.hold1", 4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b0, 1'b1);

    // Holder 1 drops its request early; requester 3 takes over next edge.
    tick("t3.drop", 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b1);
    tick("t3.hold3", 4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1);
    tick("t3.idle", 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1);
    tick("t3.idle2", 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Datapath: Sal follows Ent[Sel] one edge late, clears after release.
    tick("t5.grant", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0);
    tick("t5.sal1", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    tick("t5.sal0", 4'b0100, 4'b1011, 4'b0100, 2'd2, 1'b0, 1'b1);
    tick("t5.drop", 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
    tick("t5.clr", 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);

    // All requesting from Ptr=3: rotate 3,0,1,2,3 with 4 cycles each.
    ent2 = 4'b1010;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        s  = 2'(3 + r);
        ps = (c == 0) ? s - 2'd1 : s;
        if (r == 0 && c == 0)
          tick("t2.first", 4'b1111, ent2, 4'b1000, s, 1'b0, 1'b0);
        else
          tick("t2.rot", 4'b1111, ent2, 4'b0001 << s, s, ent2[ps], 1'b1);
      end
    end

    // Asynchronous reset in the middle of a grant.
    #3;
    Rst = 1'b1;
    Req = 4'b1010;
    Ent = 4'b1111;
    #1;
    chk_zero("t6.async");
    @(posedge Clk);
    #1;
    chk_zero("t6.held");
    @(negedge Clk);
    Rst = 1'b0;
    tick("t6.grant1", 4'b1010, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0);
    tick("t6.sal", 4'b1010, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
